// File: rtl/ahb_mem_slave.sv
// AHB-Lite memory slave with a configurable wait-state count and error responses for illegal transfers.
// The word store uses little-endian byte lanes.
module ahb_mem_slave #(
    parameter int WAIT_STATES = 1,
    parameter int MEM_WORDS   = 256
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [31:0] hwdata,
    input  logic        hready,
    output logic        hreadyout,
    output logic [1:0]  hresp,
    output logic [31:0] hrdata
);
    localparam int AW = $clog2(MEM_WORDS);

    typedef enum logic [1:0] {IDLE, WAIT, ERR1, ERR2} state_t;

    state_t          state, state_d;
    logic [2:0]      cnt, cnt_d;
    logic            active, active_d;
    logic            accept, illegal, done;
    logic [AW+1:0]   addr_p1;
    logic            write_p1;
    logic [1:0]      size_p1;
    logic [3:0]      be_p1;
    logic [31:0]     mem [MEM_WORDS];
    logic            unused_ok;

    // BUSY and NONSEQ/SEQ are told apart by htrans[1] alone.
    assign unused_ok = htrans[0];

    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] a);
        case (size)
            2'b00:   return 4'b0001 << a;
            2'b01:   return a[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    assign illegal = (64'(haddr) >= 64'(MEM_WORDS) * 64'd4) ||
                     (hsize > 3'b010) ||
                     ((hsize == 3'b001) && haddr[0]) ||
                     ((hsize == 3'b010) && (haddr[1:0] != 2'b00));

    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        active_d  = active;
        hreadyout = 1'b1;
        hresp     = 2'b00;
        case (state)
            WAIT:    if (cnt != 3'd0) hreadyout = 1'b0;
            ERR1:    begin hreadyout = 1'b0; hresp = 2'b01; end
            ERR2:    hresp = 2'b01;
            default: ;
        endcase
        accept = hsel && htrans[1] && hready && hreadyout;
        if (!hreadyout) begin
            if (state == ERR1) state_d = ERR2;
            else               cnt_d   = cnt - 3'd1;
        end else begin
            // Any ready cycle closes the current data phase and may open the next one.
            state_d  = IDLE;
            active_d = 1'b0;
            if (accept) begin
                if (illegal) begin
                    state_d = ERR1;
                end else begin
                    active_d = 1'b1;
                    if (WAIT_STATES != 0) begin
                        state_d = WAIT;
                        cnt_d   = 3'(WAIT_STATES);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= IDLE;
            cnt    <= 3'd0;
            active <= 1'b0;
        end else begin
            state  <= state_d;
            cnt    <= cnt_d;
            active <= active_d;
        end
    end

    // Address phase -> data phase
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_p1  <= haddr[AW+1:0];
            write_p1 <= hwrite;
            size_p1  <= hsize[1:0];
        end
    end

    assign done  = active && hreadyout;
    assign be_p1 = byte_en(size_p1, addr_p1[1:0]);

    // Data phase -> storage; a read accepted in this cycle sees the update next cycle.
    always_ff @(posedge clk) begin
        if (done && write_p1) begin
            for (int i = 0; i < 4; i++) begin
                if (be_p1[i]) mem[addr_p1[AW+1:2]][8*i +: 8] <= hwdata[8*i +: 8];
            end
        end
    end

    assign hrdata = (done && !write_p1) ? mem[addr_p1[AW+1:2]] : 32'h0;
endmodule

// File: tb/tb_ahb_mem_slave.sv
// Directed bench for ahb_mem_slave: one instance with WAIT_STATES=1 and one with WAIT_STATES=0.
// Shared clock and reset.
module tb_ahb_mem_slave;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;

    logic        hsel1, hwrite1, hready1, hreadyout1;
    logic [31:0] haddr1, hwdata1, hrdata1;
    logic [1:0]  htrans1, hresp1;
    logic [2:0]  hsize1;

    logic        hsel0, hwrite0, hready0, hreadyout0;
    logic [31:0] haddr0, hwdata0, hrdata0;
    logic [1:0]  htrans0, hresp0;
    logic [2:0]  hsize0;

    int checks = 0;
    int passed = 0;

    assign hready1 = hreadyout1;
    assign hready0 = hreadyout0;

    always #5 clk = ~clk;

    ahb_mem_slave #(.WAIT_STATES(1), .MEM_WORDS(256)) dut1 (
        .clk(clk), .rstn(rstn), .hsel(hsel1), .haddr(haddr1), .htrans(htrans1),
        .hwrite(hwrite1), .hsize(hsize1), .hwdata(hwdata1), .hready(hready1),
        .hreadyout(hreadyout1), .hresp(hresp1), .hrdata(hrdata1)
    );

    ahb_mem_slave #(.WAIT_STATES(0), .MEM_WORDS(256)) dut0 (
        .clk(clk), .rstn(rstn), .hsel(hsel0), .haddr(haddr0), .htrans(htrans0),
        .hwrite(hwrite0), .hsize(hsize0), .hwdata(hwdata0), .hready(hready0),
        .hreadyout(hreadyout0), .hresp(hresp0), .hrdata(hrdata0)
    );

    // One non-pipelined transfer on dut1; samples the first and last data-phase cycles.
    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                        input logic [31:0] wdata, output int waits,
                        output logic [1:0] resp_first, output logic [31:0] rd_first,
                        output logic [1:0] resp_last, output logic [31:0] rd_last);
        @(negedge clk);
        hsel1 = 1'b1; htrans1 = 2'b10; haddr1 = addr; hwrite1 = wr; hsize1 = size;
        @(negedge clk);
        hsel1 = 1'b0; htrans1 = 2'b00; hwdata1 = wdata;
        resp_first = hresp1; rd_first = hrdata1; waits = 0;
        while (!hreadyout1 && waits < 16) begin
            waits++;
            @(negedge clk);
        end
        resp_last = hresp1; rd_last = hrdata1;
    endtask

    task automatic test_reset();
        checks++; if (hreadyout1 !== 1'b1) $display("FAIL rst_hreadyout1 got=%b exp=1", hreadyout1); else passed++;
        checks++; if (hresp1 !== 2'b00) $display("FAIL rst_hresp1 got=%b exp=00", hresp1); else passed++;
        checks++; if (hrdata1 !== 32'h0) $display("FAIL rst_hrdata1 got=%h exp=0", hrdata1); else passed++;
        checks++; if (hreadyout0 !== 1'b1) $display("FAIL rst_hreadyout0 got=%b exp=1", hreadyout0); else passed++;
    endtask

    task automatic test_word_rw();
        int w; logic [1:0] rf, rl; logic [31:0] df, dl;
        xfer(1'b1, 32'h10, 3'b010, 32'hDEADBEEF, w, rf, df, rl, dl);
        checks++; if (w !== 1) $display("FAIL wr_waits got=%0d exp=1", w); else passed++;
        checks++; if (rl !== 2'b00) $display("FAIL wr_resp got=%b exp=00", rl); else passed++;
        xfer(1'b0, 32'h10, 3'b010, 32'h0, w, rf, df, rl, dl);
        checks++; if (w !== 1) $display("FAIL rd_waits got=%0d exp=1", w); else passed++;
        checks++; if (df !== 32'h0) $display("FAIL rd_wait_data got=%h exp=0", df); else passed++;
        checks++; if (dl !== 32'hDEADBEEF) $display("FAIL rd_data got=%h exp=deadbeef", dl); else passed++;
        checks++; if (rl !== 2'b00) $display("FAIL rd_resp got=%b exp=00", rl); else passed++;
    endtask

    task automatic test_lanes();
        int w; logic [1:0] rf, rl; logic [31:0] df, dl;
        xfer(1'b1, 32'h10, 3'b010, 32'h11223344, w, rf, df, rl, dl);
        xfer(1'b1, 32'h13, 3'b000, 32'hAA000000, w, rf, df, rl, dl);
        xfer(1'b0, 32'h10, 3'b010, 32'h0, w, rf, df, rl, dl);
        checks++; if (dl !== 32'hAA223344) $display("FAIL byte_lane3 got=%h exp=aa223344", dl); else passed++;
        xfer(1'b1, 32'h10, 3'b001, 32'h00005566, w, rf, df, rl, dl);
        xfer(1'b0, 32'h10, 3'b010, 32'h0, w, rf, df, rl, dl);
        checks++; if (dl !== 32'hAA225566) $display("FAIL half_lane0 got=%h exp=aa225566", dl); else passed++;
        xfer(1'b1, 32'h12, 3'b001, 32'hCAFE0000, w, rf, df, rl, dl);
        xfer(1'b0, 32'h10, 3'b010, 32'h0, w, rf, df, rl, dl);
        checks++; if (dl !== 32'hCAFE5566) $display("FAIL half_lane1 got=%h exp=cafe5566", dl); else passed++;
    endtask

    task automatic test_errors();
        int w; logic [1:0] rf, rl; logic [31:0] df, dl;
        xfer(1'b0, 32'h400, 3'b010, 32'h0, w, rf, df, rl, dl);
        checks++; if (w !== 1) $display("FAIL err_range_waits got=%0d exp=1", w); else passed++;
        checks++; if (rf !== 2'b01) $display("FAIL err_range_err1 got=%b exp=01", rf); else passed++;
        checks++; if (rl !== 2'b01) $display("FAIL err_range_err2 got=%b exp=01", rl); else passed++;
        checks++; if (dl !== 32'h0) $display("FAIL err_range_data got=%h exp=0", dl); else passed++;
        xfer(1'b0, 32'h02, 3'b010, 32'h0, w, rf, df, rl, dl);
        checks++; if (w !== 1) $display("FAIL err_align_waits got=%0d exp=1", w); else passed++;
        checks++; if (rf !== 2'b01) $display("FAIL err_align_err1 got=%b exp=01", rf); else passed++;
        checks++; if (rl !== 2'b01) $display("FAIL err_align_err2 got=%b exp=01", rl); else passed++;
        checks++; if (dl !== 32'h0) $display("FAIL err_align_data got=%h exp=0", dl); else passed++;
        xfer(1'b1, 32'h12, 3'b010, 32'h12345678, w, rf, df, rl, dl);
        checks++; if (rl !== 2'b01) $display("FAIL err_wr_align got=%b exp=01", rl); else passed++;
        xfer(1'b1, 32'h11, 3'b001, 32'h12345678, w, rf, df, rl, dl);
        checks++; if (rl !== 2'b01) $display("FAIL err_wr_half_align got=%b exp=01", rl); else passed++;
        xfer(1'b1, 32'h10, 3'b011, 32'h12345678, w, rf, df, rl, dl);
        checks++; if (rl !== 2'b01) $display("FAIL err_wr_size got=%b exp=01", rl); else passed++;
        xfer(1'b1, 32'h410, 3'b010, 32'h12345678, w, rf, df, rl, dl);
        checks++; if (rl !== 2'b01) $display("FAIL err_wr_range got=%b exp=01", rl); else passed++;
        xfer(1'b0, 32'h10, 3'b010, 32'h0, w, rf, df, rl, dl);
        checks++; if (dl !== 32'hCAFE5566) $display("FAIL err_no_write got=%h exp=cafe5566", dl); else passed++;
    endtask

    task automatic test_idle_busy();
        int w; logic [1:0] rf, rl; logic [31:0] df, dl;
        @(negedge clk);
        hsel1 = 1'b1; htrans1 = 2'b01; hwrite1 = 1'b1; haddr1 = 32'h10; hsize1 = 3'b010;
        @(negedge clk);
        checks++; if (hreadyout1 !== 1'b1) $display("FAIL busy_ready got=%b exp=1", hreadyout1); else passed++;
        checks++; if (hresp1 !== 2'b00) $display("FAIL busy_resp got=%b exp=00", hresp1); else passed++;
        hwdata1 = 32'hFFFFFFFF;
        hsel1 = 1'b0; htrans1 = 2'b10;
        @(negedge clk);
        checks++; if (hreadyout1 !== 1'b1) $display("FAIL nosel_ready got=%b exp=1", hreadyout1); else passed++;
        checks++; if (hresp1 !== 2'b00) $display("FAIL nosel_resp got=%b exp=00", hresp1); else passed++;
        htrans1 = 2'b00;
        @(negedge clk);
        xfer(1'b0, 32'h10, 3'b010, 32'h0, w, rf, df, rl, dl);
        checks++; if (dl !== 32'hCAFE5566) $display("FAIL idle_no_write got=%h exp=cafe5566", dl); else passed++;
    endtask

    task automatic test_reset_mid();
        int w; logic [1:0] rf, rl; logic [31:0] df, dl;
        xfer(1'b1, 32'h20, 3'b010, 32'h0BADF00D, w, rf, df, rl, dl);
        @(negedge clk);
        hsel1 = 1'b1; htrans1 = 2'b10; haddr1 = 32'h20; hwrite1 = 1'b1; hsize1 = 3'b010;
        @(negedge clk);
        checks++; if (hreadyout1 !== 1'b0) $display("FAIL rstmid_wait got=%b exp=0", hreadyout1); else passed++;
        hsel1 = 1'b0; htrans1 = 2'b00; hwdata1 = 32'h55555555;
        #1 rstn = 1'b0;
        #1;
        checks++; if (hreadyout1 !== 1'b1) $display("FAIL rstmid_ready got=%b exp=1", hreadyout1); else passed++;
        checks++; if (hresp1 !== 2'b00) $display("FAIL rstmid_resp got=%b exp=00", hresp1); else passed++;
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        xfer(1'b0, 32'h20, 3'b010, 32'h0, w, rf, df, rl, dl);
        checks++; if (dl !== 32'h0BADF00D) $display("FAIL rstmid_old got=%h exp=0badf00d", dl); else passed++;
    endtask

    task automatic test_back_to_back();
        // dut1: read address phase held during the write's wait cycle, accepted in its final cycle
        @(negedge clk);
        hsel1 = 1'b1; htrans1 = 2'b10; haddr1 = 32'h30; hwrite1 = 1'b1; hsize1 = 3'b010;
        @(negedge clk);
        checks++; if (hreadyout1 !== 1'b0) $display("FAIL b2b1_wr_wait got=%b exp=0", hreadyout1); else passed++;
        hwdata1 = 32'h2468ACE0; hwrite1 = 1'b0;
        @(negedge clk);
        checks++; if (hreadyout1 !== 1'b1) $display("FAIL b2b1_wr_done got=%b exp=1", hreadyout1); else passed++;
        @(negedge clk);
        checks++; if (hreadyout1 !== 1'b0) $display("FAIL b2b1_rd_wait got=%b exp=0", hreadyout1); else passed++;
        hsel1 = 1'b0; htrans1 = 2'b00;
        @(negedge clk);
        checks++; if (hreadyout1 !== 1'b1) $display("FAIL b2b1_rd_done got=%b exp=1", hreadyout1); else passed++;
        checks++; if (hrdata1 !== 32'h2468ACE0) $display("FAIL b2b1_rd_data got=%h exp=2468ace0", hrdata1); else passed++;

        // dut0: zero-wait write then read of the same word
        @(negedge clk);
        hsel0 = 1'b1; htrans0 = 2'b10; haddr0 = 32'h0; hwrite0 = 1'b1; hsize0 = 3'b010;
        @(negedge clk);
        checks++; if (hreadyout0 !== 1'b1) $display("FAIL b2b0_wr_ready got=%b exp=1", hreadyout0); else passed++;
        hwdata0 = 32'h13579BDF; hwrite0 = 1'b0;
        @(negedge clk);
        checks++; if (hreadyout0 !== 1'b1) $display("FAIL b2b0_rd_ready got=%b exp=1", hreadyout0); else passed++;
        checks++; if (hrdata0 !== 32'h13579BDF) $display("FAIL b2b0_fwd got=%h exp=13579bdf", hrdata0); else passed++;
        checks++; if (hresp0 !== 2'b00) $display("FAIL b2b0_resp got=%b exp=00", hresp0); else passed++;
        hsel0 = 1'b0; htrans0 = 2'b00;
        @(negedge clk);
        checks++; if (hrdata0 !== 32'h0) $display("FAIL b2b0_idle_data got=%h exp=0", hrdata0); else passed++;
    endtask

    initial begin
        hsel1 = 1'b0; htrans1 = 2'b00; haddr1 = 32'h0; hwrite1 = 1'b0; hsize1 = 3'b010; hwdata1 = 32'h0;
        hsel0 = 1'b0; htrans0 = 2'b00; haddr0 = 32'h0; hwrite0 = 1'b0; hsize0 = 3'b010; hwdata0 = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        test_reset();
        rstn = 1'b1;
        test_word_rw();
        test_lanes();
        test_errors();
        test_idle_busy();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run exceeded time limit after %0d checks", checks);
        $fatal(1);
    end
endmodule

// File: doc/ahb_mem_slave.md
AHB_MEM_SLAVE -- requirements
Module: ahb_mem_slave

Interface
REQ-001 SHALL have parameter WAIT_STATES, default 1, meaning the number of data-phase wait cycles per accepted OKAY transfer (legal range 0..7).
REQ-002 SHALL have parameter MEM_WORDS, default 256, meaning the depth of the 32-bit word storage (power of two).
REQ-003 clk  input  1  bus clock; all state updates on rising edge.
REQ-004 rstn  input  1  reset, asynchronous assert, active-low.
REQ-005 hsel  input  1  slave select from the address decoder.
REQ-006 haddr  input  32  byte address, address phase.
REQ-007 htrans  input  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
REQ-008 hwrite  input  1  1 = write, 0 = read.
REQ-009 hsize  input  3  000 byte, 001 halfword, 010 word; others illegal.
REQ-010 hwdata  input  32  write data, data phase.
REQ-011 hready  input  1  bus-level ready (muxed HREADY).
REQ-012 hreadyout  output  1  this slave's ready.
REQ-013 hresp  output  2  00 OKAY, 01 ERROR.
REQ-014 hrdata  output  32  read data, valid when hreadyout=1 in a read data phase.

Function
REQ-015 An address phase SHALL be accepted only when hsel=1, htrans[1]=1 and hready=1 on the same rising edge; haddr, hwrite and hsize SHALL be captured at that edge.
REQ-016 IDLE or BUSY transfers, or hsel=0, SHALL give a zero-wait OKAY response (hreadyout=1, hresp=00) in the following cycle.
REQ-017 An accepted transfer is illegal if haddr >= MEM_WORDS*4, hsize > 010, or haddr is misaligned to hsize (halfword: haddr[0]=1; word: haddr[1:0]!=00).
REQ-018 The FSM SHALL have states IDLE, WAIT, ERR1 and ERR2.
REQ-019 IDLE -> WAIT on a legal accept with WAIT_STATES>0; remains IDLE (zero-wait completion) on a legal accept with WAIT_STATES=0; IDLE -> ERR1 on an illegal accept.
REQ-020 WAIT SHALL drive hreadyout=0 and hresp=00 for exactly WAIT_STATES cycles (down-counter, 3 bits), then drive hreadyout=1 and hresp=00 for one cycle, in which a new accept is permitted (back-to-back pipelining).
REQ-021 ERR1 SHALL drive hreadyout=0, hresp=01; ERR2 SHALL drive hreadyout=1, hresp=01; ERR2 -> IDLE, or it SHALL take a new accept in the same cycle per REQ-015.
REQ-022 An illegal transfer SHALL NOT modify memory, and hrdata SHALL be 0 during ERR1/ERR2.
REQ-023 A write SHALL update memory on the edge ending the final (hreadyout=1) data-phase cycle using hwdata, with byte lanes little-endian: byte lane = haddr[1:0], halfword lane = haddr[1]; unselected bytes SHALL be preserved.
REQ-024 A read SHALL present the full addressed word on hrdata in the final data-phase cycle; the data is not lane-masked; read data is 0 in all other cycles.
REQ-025 A read whose address phase overlaps the final cycle of a write to the same word SHALL return the newly written data (write-to-read forwarding).
REQ-026 Total latency for a legal transfer SHALL be WAIT_STATES+1 cycles from accept to completion; an error SHALL always take 2 cycles.
REQ-027 Address-phase inputs SHALL be ignored while hreadyout=0.

Reset
REQ-028 On rstn=0 the block SHALL immediately set the FSM to IDLE, the wait counter to 0, hreadyout=1, hresp=00 and hrdata=0, and SHALL discard any in-flight transfer without a memory write.
REQ-029 Memory contents SHALL NOT be reset; reads before the first write are undefined.
REQ-030 The first accept SHALL be possible on the first rising edge with rstn=1.

Verification
REQ-031 WAIT_STATES=1: word write 0xDEADBEEF to 0x10, then read 0x10 -> exactly one hreadyout=0 cycle per transfer, then hrdata=0xDEADBEEF, hresp=00.
REQ-032 Byte write 0xAA to 0x13 over word 0x11223344 -> a read of 0x10 returns 0xAA223344; a halfword write 0x5566 to 0x10 then returns 0xAA225566.
REQ-033 Read of 0x400 (MEM_WORDS=256) and word read of 0x02 -> each gives ERR1 (hreadyout=0, hresp=01) then ERR2 (hreadyout=1, hresp=01), with no memory change.
REQ-034 WAIT_STATES=0: back-to-back NONSEQ write 0x0 / read 0x0 -> hreadyout held at 1 and the read returns the forwarded write data.
REQ-035 rstn pulled low during a WAIT-state write to 0x20 -> hreadyout=1 and hresp=00 immediately, and a later read of 0x20 shows the old value.
REQ-036 htrans=BUSY with hsel=1, and htrans=NONSEQ with hsel=0 -> zero-wait OKAY, and no memory write.
